fir_out_decim: RTL



---
 rtl/fir_pkg.sv | 18 +
 rtl/fir_out_decim_if.sv | 31 +++
 rtl/fir_out_fifo.sv | 61 ++++++
 rtl/fir_out_decim.sv | 102 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// Constants shared between the FIR and its output decimation stage.
package fir_pkg;

    localparam int FIR_DATA_W = 16;
    localparam int FIR_COEF_W = 8;
    localparam int OUT_W_DEF  = 8;
    localparam int SHIFT_DEF  = 8;
    localparam int DECIM_DEF  = 4;
    localparam int DEPTH_DEF  = 4;

    function automatic int clog2(input int value);
        int res;
        res = 0;
        while ((1 << res) < value) res++;
        return res;
    endfunction

endpackage

// File: rtl/fir_out_decim_if.sv
// Sample-in / result-out bundle of the decimation stage, plus its status flags.
interface fir_out_decim_if
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_DATA_W,
    parameter int OUT_W = OUT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
);
    localparam int LVL_W = clog2(DEPTH) + 1;

    logic             in_valid;
    logic [IN_W-1:0]  din;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] dout;
    logic [LVL_W-1:0] level;
    logic             ovf;
    logic             sat;
    logic             clr_flags;

    modport slave (
        input  in_valid, din, out_ready, clr_flags,
        output out_valid, dout, level, ovf, sat
    );

    modport master (
        output in_valid, din, out_ready, clr_flags,
        input  out_valid, dout, level, ovf, sat
    );

endinterface

// File: rtl/fir_out_fifo.sv
// Show-ahead FIFO: head is visible on data_o whenever not empty, zero otherwise.
module fir_out_fifo
    import fir_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    push_i,
    input  logic                    pop_i,
    input  logic [W-1:0]            data_i,
    output logic [W-1:0]            data_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [clog2(DEPTH):0]   count_o
);
    localparam int AW = clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

    // A full FIFO can still take a write when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (do_pop && !do_push) count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/fir_out_decim.sv
// Keeps one FIR sample in DECIM, rounds/shifts/saturates it to OUT_W bits and queues it.
module fir_out_decim
    import fir_pkg::*;
#(
    parameter int IN_W  = FIR_DATA_W,
    parameter int OUT_W = OUT_W_DEF,
    parameter int SHIFT = SHIFT_DEF,
    parameter int DECIM = DECIM_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic            clk,
    input  logic            reset,
    fir_out_decim_if.slave  bus
);
    localparam int PH_W   = (DECIM > 1) ? clog2(DECIM) : 1;
    localparam int RND_SH = (SHIFT > 0) ? SHIFT - 1 : 0;
    localparam logic [IN_W:0] RND   = (SHIFT > 0) ? ((IN_W+1)'(1) << RND_SH) : '0;
    localparam logic [IN_W:0] MAX_R = (IN_W+1)'((1 << OUT_W) - 1);

    logic [PH_W-1:0]  phase_q, phase_d;
    logic             stage_valid_q, stage_valid_d;
    logic [OUT_W-1:0] stage_data_q, stage_data_d;
    logic             ovf_q, ovf_d;
    logic             sat_q, sat_d;

    logic             keep;
    logic [IN_W:0]    sum, r;
    logic             clip;
    logic [OUT_W-1:0] result;
    logic             fifo_full, fifo_empty, pop, drop;
    logic [OUT_W-1:0] fifo_head;
    logic [clog2(DEPTH):0] fifo_count;

    assign keep = bus.in_valid && (phase_q == '0);

    // One extra bit so that rounding up a near-full-scale sample cannot wrap.
    always_comb begin
        sum    = {1'b0, bus.din} + RND;
        r      = sum >> SHIFT;
        clip   = (r > MAX_R);
        result = clip ? '1 : r[OUT_W-1:0];
    end

    assign pop  = !fifo_empty && bus.out_ready;
    assign drop = stage_valid_q && fifo_full && !pop;

    always_comb begin
        phase_d       = phase_q;
        stage_valid_d = keep;
        stage_data_d  = stage_data_q;
        ovf_d         = ovf_q;
        sat_d         = sat_q;
        if (bus.in_valid)
            phase_d = (phase_q == PH_W'(DECIM - 1)) ? '0 : phase_q + 1'b1;
        if (keep)
            stage_data_d = result;
        if (bus.clr_flags) begin
            ovf_d = 1'b0;
            sat_d = 1'b0;
        end
        if (drop)        ovf_d = 1'b1;
        if (keep && clip) sat_d = 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q       <= '0;
            stage_valid_q <= 1'b0;
            stage_data_q  <= '0;
            ovf_q         <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            phase_q       <= phase_d;
            stage_valid_q <= stage_valid_d;
            stage_data_q  <= stage_data_d;
            ovf_q         <= ovf_d;
            sat_q         <= sat_d;
        end
    end

    fir_out_fifo #(
        .W     (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (stage_valid_q),
        .pop_i   (pop),
        .data_i  (stage_data_q),
        .data_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign bus.out_valid = !fifo_empty;
    assign bus.dout      = fifo_head;
    assign bus.level     = fifo_count;
    assign bus.ovf       = ovf_q;
    assign bus.sat       = sat_q;

endmodule
